// File: rtl/mul16_arb.sv
// mul16_arb: shares one signed 16x16 multiplier among NREQ requesters over valid/ready channels.
// Define MUL16_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module mul16_arb #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*16-1:0]   req_a,
   input  logic [NREQ*16-1:0]   req_b,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [31:0]          resp_data,
   output logic [ID_W-1:0]      resp_id
);

   typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

   state_t          state, state_nxt;
   logic [15:0]     a_r, b_r;
   logic [ID_W-1:0] id_r, last_g, gnt_idx;
   logic [15:0]     sel_a, sel_b;
   logic            gnt_any, grant_ok, take;
   logic [31:0]     mul_p;

   // NOTE: every variable written in an always_comb gets a default first, so no path leaves it
   // holding its old value (which would infer a latch).
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      sel_a   = '0;
      sel_b   = '0;
      for (int k = 0; k < NREQ; k++) begin
         int j;
`ifdef MUL16_ARB_RR_EN
         j = (int'(last_g) + 1 + k) % NREQ;
`else
         j = k;
`endif
         if (!gnt_any && req_valid[j]) begin
            gnt_any = 1'b1;
            gnt_idx = ID_W'(j);
            sel_a   = req_a[16*j +: 16];
            sel_b   = req_b[16*j +: 16];
         end
      end
   end

`ifndef MUL16_ARB_RR_EN
   // The pointer is still maintained in the fixed-priority build; only the search ignores it.
   logic unused_last_g;
   assign unused_last_g = ^last_g;
`endif

   // A new grant is possible from IDLE, or from HOLD in the same cycle the result is consumed.
   always_comb begin
      state_nxt = state;
      grant_ok  = 1'b0;
      case (state)
         IDLE: begin
            grant_ok = 1'b1;
            if (gnt_any) state_nxt = MUL;
         end
         MUL:  state_nxt = HOLD;
         HOLD: begin
            if (resp_ready) begin
               grant_ok  = 1'b1;
               state_nxt = gnt_any ? MUL : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign take = grant_ok && gnt_any && !rst;

   always_comb begin
      req_ready = '0;
      if (take) req_ready[gnt_idx] = 1'b1;
   end

   assign resp_valid = (state == HOLD);

   // Operands are sign-extended to the full product width, so the low 32 bits are the exact result.
   assign mul_p = $signed({{16{a_r[15]}}, a_r}) * $signed({{16{b_r[15]}}, b_r});

   // NOTE: sequential state uses non-blocking assignments only, so every register samples the
   // pre-edge values regardless of statement order. All registers are reset; there is no memory here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         a_r       <= '0;
         b_r       <= '0;
         id_r      <= '0;
         last_g    <= ID_W'(NREQ - 1);
         resp_data <= '0;
         resp_id   <= '0;
      end else begin
         state <= state_nxt;
         if (take) begin
            a_r    <= sel_a;
            b_r    <= sel_b;
            id_r   <= gnt_idx;
            last_g <= gnt_idx;
         end
         if (state == MUL) begin
            resp_data <= mul_p;
            resp_id   <= id_r;
         end
      end
   end

endmodule

// File: tb/tb_mul16_arb.sv
// tb_mul16_arb: directed and randomized checks of mul16_arb against a transaction-level model.
// Build with or without MUL16_ARB_RR_EN to match the design build.
module tb_mul16_arb;

   localparam int NREQ = 4;
   localparam int ID_W = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*16-1:0]  req_a;
   logic [NREQ*16-1:0]  req_b;
   logic                resp_valid;
   logic                resp_ready;
   logic [31:0]         resp_data;
   logic [ID_W-1:0]     resp_id;

   mul16_arb #(.NREQ(NREQ), .ID_W(ID_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_id    (resp_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [31:0] p;
   } op_t;

   op_t             exp_q[$];
   int unsigned     total = 0;
   int unsigned     bad   = 0;
   int              cyc = 0, acc_cyc = 0, m_last = NREQ - 1, last_grant = -1;
   int              n_acc = 0, n_resp = 0;
   bit              out_pend = 1'b0;
   logic [NREQ-1:0] acc_mask = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Which requester should win, given the last granted index.
   function automatic int pick(input logic [NREQ-1:0] v);
`ifdef MUL16_ARB_RR_EN
      for (int k = 1; k <= NREQ; k++)
         if (v[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
`else
      for (int k = 0; k < NREQ; k++)
         if (v[k]) return k;
`endif
      return -1;
   endfunction

   function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      return 32'(sa * sb);
   endfunction

   // One clock: compare outputs with the model at the falling edge, then advance the model to
   // what the coming rising edge commits. Inputs change 1 time unit after the rising edge.
   task automatic cycle();
      logic [NREQ-1:0] exp_rdy;
      logic            exp_rv;
      int              g;
      op_t             op;
      @(negedge clk);
      exp_rv  = out_pend && (cyc >= acc_cyc + 2);
      exp_rdy = '0;
      g       = -1;
      if (!rst && (!out_pend || (exp_rv && resp_ready)) && (req_valid != '0)) begin
         g = pick(req_valid);
         exp_rdy[g] = 1'b1;
      end
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (exp_rv && exp_q.size() > 0) begin
         check("resp_data", resp_data, exp_q[0].p);
         check("resp_id", 32'(resp_id), 32'(exp_q[0].id));
      end
      acc_mask = '0;
      if (rst) begin
         out_pend = 1'b0;
         exp_q.delete();
         m_last = NREQ - 1;
      end else begin
         if (exp_rv && resp_ready) begin
            void'(exp_q.pop_front());
            out_pend = 1'b0;
            n_resp++;
         end
         if (g >= 0) begin
            op.id = g;
            op.p  = ref_mul(req_a[16*g +: 16], req_b[16*g +: 16]);
            exp_q.push_back(op);
            out_pend    = 1'b1;
            acc_cyc     = cyc;
            m_last      = g;
            last_grant  = g;
            acc_mask[g] = 1'b1;
            n_acc++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp);
      req_valid           = '0;
      req_valid[i]        = 1'b1;
      req_a[16*i +: 16]   = a;
      req_b[16*i +: 16]   = b;
      resp_ready          = 1'b1;
      cycle();
      check("op_accept", 32'(acc_mask), 32'(1) << i);
      req_valid = '0;
      cycle();
      check("op_rv", 32'(resp_valid), 32'(1));
      check("op_data", resp_data, exp);
      check("op_id", 32'(resp_id), 32'(i));
      cycle();
   endtask

   function automatic logic [15:0] rand_opnd();
      case ($urandom_range(0, 7))
         0:       return 16'h8000;
         1:       return 16'h7FFF;
         2:       return 16'h0000;
         3:       return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t3_exp[5];
      int ng, prev, base_acc, base_resp;

      rst        = 1'b1;
      req_valid  = '1;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;

      // T1: reset held with all requesters valid
      for (int c = 0; c < 3; c++) begin
         check("t1_ready", 32'(req_ready), 32'(0));
         check("t1_rv", 32'(resp_valid), 32'(0));
         check("t1_data", resp_data, 32'h0);
         cycle();
      end
      rst       = 1'b0;
      req_valid = '0;
      cycle();

      // T2: single operations, including sign and full-range boundaries
      run_op(0, 16'h8000, 16'h0006, 32'hFFFD0000);
      run_op(0, 16'h7FFF, 16'h7FFF, 32'h3FFF0001);
      run_op(0, 16'hF000, 16'hF000, 32'h01000000);
      run_op(1, 16'h8000, 16'h8000, 32'h40000000);
      run_op(3, 16'hFFFF, 16'h0001, 32'hFFFFFFFF);

      // T3: all requesters valid, consumer always ready
`ifdef MUL16_ARB_RR_EN
      t3_exp = '{0, 1, 2, 3, 0};
`else
      t3_exp = '{0, 0, 0, 0, 0};
`endif
      rst = 1'b1;
      cycle();
      rst        = 1'b0;
      resp_ready = 1'b1;
      req_valid  = '1;
      for (int i = 0; i < NREQ; i++) begin
         req_a[16*i +: 16] = 16'(i + 1);
         req_b[16*i +: 16] = 16'h0003;
      end
      ng   = 0;
      prev = 0;
      for (int c = 0; c < 10; c++) begin
         cycle();
         if (acc_mask != '0) begin
            if (ng < 5) check($sformatf("t3_grant%0d", ng), 32'(last_grant), 32'(t3_exp[ng]));
            if (ng > 0) check("t3_gap", 32'(cyc - prev), 32'(2));
            prev = cyc;
            ng++;
         end
      end
      check("t3_count", 32'(ng), 32'(5));
      req_valid = '0;
      repeat (3) cycle();

      // T4: backpressure on a held result with another requester waiting
      req_valid     = 4'b0001;
      req_a[15:0]   = 16'd2;
      req_b[15:0]   = 16'd4;
      resp_ready    = 1'b0;
      cycle();
      req_valid     = 4'b0010;
      req_a[31:16]  = 16'd5;
      req_b[31:16]  = 16'd7;
      cycle();
      for (int c = 0; c < 5; c++) begin
         check("t4_rv", 32'(resp_valid), 32'(1));
         check("t4_data", resp_data, 32'h00000008);
         check("t4_id", 32'(resp_id), 32'(0));
         check("t4_ready", 32'(req_ready), 32'(0));
         cycle();
      end
      resp_ready = 1'b1;
      #1;
      check("t4_regrant", 32'(req_ready), 32'(4'b0010));
      cycle();
      req_valid = '0;
      cycle();
      check("t4_data2", resp_data, 32'd35);
      check("t4_id2", 32'(resp_id), 32'(1));
      repeat (2) cycle();

      // T5: reset while an operation is in the multiply cycle
      run_op(2, 16'h0003, 16'h0003, 32'd9);
      req_valid = '1;
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("t5_rv", 32'(resp_valid), 32'(0));
      cycle();
      check("t5_grant", 32'(last_grant), 32'(0));
      req_valid = '0;
      repeat (3) cycle();

      // T6: randomized traffic and backpressure
      base_acc  = n_acc;
      base_resp = n_resp;
      for (int c = 0; c < 1000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || acc_mask[i]) begin
               req_valid[i]      = ($urandom_range(0, 2) != 0);
               req_a[16*i +: 16] = rand_opnd();
               req_b[16*i +: 16] = rand_opnd();
            end
         end
         resp_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      req_valid  = '0;
      resp_ready = 1'b1;
      repeat (4) cycle();
      check("t6_drain", 32'(exp_q.size()), 32'(0));
      check("t6_count", 32'(n_resp - base_resp), 32'(n_acc - base_acc));
      check("t6_activity", 32'(n_acc - base_acc > 100), 32'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
